// File: rtl/viterbi_frame_ctrl.sv
// Frame controller around a Viterbi decoder core: collects serial coded bits into a frame,
// hands it to the core, buffers the result and serializes the decoded word MSB first.
module viterbi_frame_ctrl #(
    parameter int unsigned CODE_BITS = 14,
    parameter int unsigned DATA_BITS = 7,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 in_bit,
    output logic                 in_ready,
    output logic                 dec_start,
    output logic [CODE_BITS-1:0] dec_code,
    input  logic                 dec_done,
    input  logic [DATA_BITS-1:0] dec_data,
    output logic                 out_valid,
    output logic                 out_bit,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [7:0]           frame_cnt
);

    localparam int unsigned OutCntW = $clog2(DATA_BITS + 1);
    localparam int unsigned TmoW    = $clog2(TIMEOUT + 1);

    localparam logic [3:0]         CollFull = 4'(CODE_BITS);
    localparam logic [OutCntW-1:0] OutLast  = OutCntW'(1);
    localparam logic [OutCntW-1:0] OutFull  = OutCntW'(DATA_BITS);
    localparam logic [TmoW-1:0]    TmoLast  = TmoW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StWait, StHold} state_e;

    state_e                 state_q, state_d;
    logic [CODE_BITS-1:0]   coll_q, coll_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [CODE_BITS-1:0]   code_q, code_d;
    logic                   start_q, start_d;
    logic [TmoW-1:0]        tmo_q, tmo_d;
    logic [DATA_BITS-1:0]   hold_q, hold_d;
    logic [DATA_BITS-1:0]   sh_q, sh_d;
    logic [OutCntW-1:0]     ocnt_q, ocnt_d;
    logic                   err_q, err_d;
    logic [7:0]             fcnt_q, fcnt_d;

    logic coll_full;
    logic in_fire;
    logic out_busy;
    logic out_fire;
    logic out_free;

    assign coll_full = (cnt_q == CollFull);
    assign in_fire   = in_valid && in_ready;
    assign out_busy  = (ocnt_q != '0);
    assign out_fire  = out_busy && out_ready;
    // Output register counts as free while its last bit is leaving, so frames run back to back.
    assign out_free  = !out_busy || (ocnt_q == OutLast && out_ready);

    always_comb begin
        state_d = state_q;
        coll_d  = coll_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        start_d = 1'b0;
        tmo_d   = tmo_q;
        hold_d  = hold_q;
        sh_d    = sh_q;
        ocnt_d  = ocnt_q;
        err_d   = err_q;
        fcnt_d  = fcnt_q;

        if (in_fire) begin
            coll_d = {in_bit, coll_q[CODE_BITS-1:1]};
            cnt_d  = cnt_q + 4'd1;
        end

        if (out_fire) begin
            sh_d   = {sh_q[DATA_BITS-2:0], 1'b0};
            ocnt_d = ocnt_q - OutLast;
            if (ocnt_q == OutLast) begin
                fcnt_d = fcnt_q + 8'd1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (coll_full) begin
                    code_d  = coll_q;
                    cnt_d   = '0;
                    start_d = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                tmo_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (dec_done) begin
                    if (out_free) begin
                        sh_d    = dec_data;
                        ocnt_d  = OutFull;
                        state_d = StIdle;
                    end else begin
                        hold_d  = dec_data;
                        state_d = StHold;
                    end
                end else if (tmo_q == TmoLast) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StHold: begin
                if (out_free) begin
                    sh_d    = hold_q;
                    ocnt_d  = OutFull;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            coll_q  <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
            start_q <= 1'b0;
            tmo_q   <= '0;
            hold_q  <= '0;
            sh_q    <= '0;
            ocnt_q  <= '0;
            err_q   <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            coll_q  <= coll_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            start_q <= start_d;
            tmo_q   <= tmo_d;
            hold_q  <= hold_d;
            sh_q    <= sh_d;
            ocnt_q  <= ocnt_d;
            err_q   <= err_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Handshake outputs are forced low while reset is held, before the first reset edge too.
    assign in_ready    = !reset && !coll_full;
    assign dec_start   = !reset && start_q;
    assign dec_code    = code_q;
    assign out_valid   = !reset && out_busy;
    assign out_bit     = out_valid ? sh_q[DATA_BITS-1] : 1'b0;
    assign busy        = !reset && (state_q != StIdle);
    assign timeout_err = err_q;
    assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Bench for viterbi_frame_ctrl: acts as the decoder core and checks the serial output
// against a frame-level queue model.
module tb_viterbi_frame_ctrl;

    localparam int unsigned CODE_BITS = 14;
    localparam int unsigned DATA_BITS = 7;
    localparam int unsigned TIMEOUT   = 15;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_bit = 1'b0;
    logic                 in_ready;
    logic                 dec_start;
    logic [CODE_BITS-1:0] dec_code;
    logic                 dec_done = 1'b0;
    logic [DATA_BITS-1:0] dec_data = '0;
    logic                 out_valid;
    logic                 out_bit;
    logic                 out_ready = 1'b0;
    logic                 busy;
    logic                 timeout_err;
    logic [7:0]           frame_cnt;

    viterbi_frame_ctrl #(
        .CODE_BITS(CODE_BITS),
        .DATA_BITS(DATA_BITS),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .in_ready   (in_ready),
        .dec_start  (dec_start),
        .dec_code   (dec_code),
        .dec_done   (dec_done),
        .dec_data   (dec_data),
        .out_valid  (out_valid),
        .out_bit    (out_bit),
        .out_ready  (out_ready),
        .busy       (busy),
        .timeout_err(timeout_err),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state
    logic                 src[$];
    logic                 acc[$];
    logic [CODE_BITS-1:0] code_q[$];
    logic                 out_q[$];
    logic [DATA_BITS-1:0] data_plan[$];
    int                   delay_plan[$];
    int                   out_pos = 0;
    logic [7:0]           fcnt_m = '0;
    logic                 err_m = 1'b0;
    logic                 resp_active = 1'b0;
    int                   resp_cnt = 0;
    int                   resp_delay = 0;
    logic [CODE_BITS-1:0] cur_code = '0;
    int                   cyc = 0;
    int                   last_full_cyc = 0;
    int                   start_cyc = 0;
    logic [CODE_BITS-1:0] first_code = '0;

    // Stimulus knobs
    logic feed_en = 1'b0;
    logic gap_en = 1'b0;
    int   ord_mode = 1;
    logic stray_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_idle();
        return src.size() == 0 && acc.size() == 0 && code_q.size() == 0 && !resp_active &&
               out_q.size() == 0;
    endfunction

    task automatic clear_model();
        src.delete();
        acc.delete();
        code_q.delete();
        out_q.delete();
        data_plan.delete();
        delay_plan.delete();
        out_pos     = 0;
        fcnt_m      = '0;
        err_m       = 1'b0;
        resp_active = 1'b0;
    endtask

    task automatic cycle();
        logic                 done_now;
        logic [DATA_BITS-1:0] data_now;
        logic [CODE_BITS-1:0] code;
        done_now = 1'b0;
        data_now = '0;
        @(negedge clk);
        cyc++;
        // Decoder-core behaviour
        if (dec_start) begin
            start_cyc = cyc;
            if (code_q.size() == 0) begin
                check("dec_start_spurious", 32'(dec_start), 32'd0);
            end else begin
                cur_code = code_q.pop_front();
                check("dec_code", 32'(dec_code), 32'(cur_code));
            end
            resp_active = 1'b1;
            resp_cnt    = 0;
            resp_delay  = (delay_plan.size() != 0) ? delay_plan.pop_front()
                                                   : int'($urandom_range(1, TIMEOUT));
        end else if (resp_active) begin
            resp_cnt++;
            if (resp_delay != 0 && resp_cnt == resp_delay) begin
                done_now    = 1'b1;
                data_now    = (data_plan.size() != 0) ? data_plan.pop_front()
                                                      : DATA_BITS'($urandom);
                resp_active = 1'b0;
                check("dec_code_stable", 32'(dec_code), 32'(cur_code));
            end else if (resp_delay == 0 && resp_cnt == TIMEOUT + 1) begin
                err_m       = 1'b1;
                resp_active = 1'b0;
                check("timeout_idle", 32'(busy), 32'd0);
            end
        end
        check("timeout_err", 32'(timeout_err), 32'(err_m));
        check("frame_cnt", 32'(frame_cnt), 32'(fcnt_m));

        // Drive inputs for the coming edge
        in_valid  = feed_en && src.size() != 0 && (!gap_en || $urandom_range(0, 3) != 0);
        in_bit    = (src.size() != 0) ? src[0] : 1'b0;
        dec_done  = done_now || stray_done;
        dec_data  = done_now ? data_now : DATA_BITS'($urandom);
        out_ready = (ord_mode == 1) || (ord_mode == 2 && $urandom_range(0, 9) < 3);
        #1;
        check("out_valid", 32'(out_valid), 32'(out_q.size() != 0));
        if (out_q.size() != 0) check("out_bit", 32'(out_bit), 32'(out_q[0]));
        else check("out_bit_idle", 32'(out_bit), 32'd0);

        if (in_valid && in_ready) begin
            acc.push_back(src.pop_front());
            if (acc.size() == CODE_BITS) begin
                code = '0;
                for (int i = 0; i < int'(CODE_BITS); i++) code[i] = acc[i];
                code_q.push_back(code);
                acc.delete();
                last_full_cyc = cyc;
            end
        end
        if (out_valid && out_ready && out_q.size() != 0) begin
            void'(out_q.pop_front());
            out_pos++;
            if (out_pos == int'(DATA_BITS)) begin
                out_pos = 0;
                fcnt_m  = fcnt_m + 8'd1;
            end
        end
        if (done_now) begin
            for (int i = int'(DATA_BITS) - 1; i >= 0; i--) out_q.push_back(data_now[i]);
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (!model_idle() && n < limit) begin
            cycle();
            n++;
        end
        check("drain_done", 32'(model_idle()), 32'd1);
        run_cycles(3);
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset      = 1'b1;
            in_valid   = 1'b0;
            dec_done   = 1'b0;
            out_ready  = 1'b0;
            #1;
            check("rst_in_ready", 32'(in_ready), 32'd0);
            check("rst_dec_start", 32'(dec_start), 32'd0);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_model();
        check("post_rst_dec_code", 32'(dec_code), 32'd0);
        check("post_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("post_rst_timeout_err", 32'(timeout_err), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
    endtask

    task automatic push_random_bits(input int n);
        for (int i = 0; i < n; i++) src.push_back(1'($urandom));
    endtask

    initial begin
        // Reset state
        reset_cycles(2);
        feed_en = 1'b1;

        // Single frame, known code word and decoded word
        ord_mode = 1;
        src.push_back(1'b1);
        for (int i = 0; i < 12; i++) src.push_back(1'b0);
        src.push_back(1'b1);
        data_plan.push_back(7'h55);
        delay_plan.push_back(2);
        while (!dec_start && cyc < 40) cycle();
        first_code = dec_code;
        drain(100);
        check("code_2001", 32'(first_code), 32'h2001);
        check("start_latency", 32'(start_cyc - last_full_cyc), 32'd2);
        check("frame_cnt_one", 32'(frame_cnt), 32'd1);

        // Back-pressure: first result in output register, second in hold, third frame parked
        ord_mode = 0;
        push_random_bits(3 * CODE_BITS);
        data_plan.push_back(7'h7F);
        data_plan.push_back(7'h01);
        data_plan.push_back(7'h2A);
        delay_plan.push_back(2);
        delay_plan.push_back(2);
        delay_plan.push_back(2);
        run_cycles(70);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_busy_hold", 32'(busy), 32'd1);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        ord_mode = 1;
        drain(200);
        check("bp_frame_cnt", 32'(frame_cnt), 32'd4);

        // Decoder never answers, then a normal frame
        push_random_bits(2 * CODE_BITS);
        delay_plan.push_back(0);
        delay_plan.push_back(3);
        drain(200);
        check("timeout_sticky", 32'(timeout_err), 32'd1);
        check("timeout_frame_cnt", 32'(frame_cnt), 32'd5);

        // Reset after a partial frame; stray dec_done afterwards
        push_random_bits(9);
        for (int i = 0; i < 50 && src.size() != 0; i++) cycle();
        reset_cycles(2);
        stray_done = 1'b1;
        cycle();
        stray_done = 1'b0;
        run_cycles(4);
        push_random_bits(CODE_BITS);
        drain(100);
        check("rst_fresh_frame_cnt", 32'(frame_cnt), 32'd1);

        // 256 frames with random gaps, delays and back-pressure
        reset_cycles(1);
        feed_en  = 1'b1;
        gap_en   = 1'b1;
        ord_mode = 2;
        push_random_bits(256 * CODE_BITS);
        drain(20000);
        check("frame_cnt_wrap", 32'(frame_cnt), 32'd0);
        check("stream_no_timeout", 32'(timeout_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
